apb_byte_master: RTL and testbench
==================================

APB_BYTE_MASTER -- requirements
Module: apb_byte_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum number of ACCESS cycles before abort (range 1-255).
REQ-002 SHALL have port pclk, input, 1, the single clock (CPU bus and APB side).
REQ-003 SHALL have port presetn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpu_cs, input, 1, register-window select from the CPU memory decoder.
REQ-005 SHALL have port cpu_we_n, input, 1, 1 = read, 0 = write.
REQ-006 SHALL have port cpu_addr, input, 4, register offset.
REQ-007 SHALL have port cpu_din, input, 8, CPU write data.
REQ-008 SHALL have port cpu_dout, output, 8, CPU read data.
REQ-009 SHALL have port paddr, output, 32, APB address.
REQ-010 SHALL have port psel, output, 8, one-hot APB slave select.
REQ-011 SHALL have port penable, output, 1, APB enable.
REQ-012 SHALL have port pwrite, output, 1, APB direction.
REQ-013 SHALL have port pwdata, output, 32, APB write data.
REQ-014 SHALL have port pready, input, 1, APB slave ready.
REQ-015 SHALL have port prdata, input, 32, APB read data.
REQ-016 SHALL have port irq, output, 1, level equal to STATUS.done OR STATUS.timeout.

Function
REQ-017 SHALL use this register map (byte lanes little-endian):
- 0x0-0x3: ADDR (R/W)
- 0x4-0x7: WDATA (R/W)
- 0x8-0xB: RDATA (read-only)
- 0xC: CTRL (write-only; reads 0)
- 0xD: STATUS (read-only)
- 0xE-0xF: reserved, read 0
REQ-018 SHALL perform a CPU write on the pclk edge when cpu_cs=1 and cpu_we_n=0; writes to read-only or reserved offsets have no effect.
REQ-019 SHALL drive cpu_dout combinationally with the addressed register byte when cpu_cs=1 and cpu_we_n=1, else 0x00.
REQ-020 SHALL decode CTRL as: bit0 start, bit1 write (1 = APB write), bits[4:2] slave index n; psel is driven as 1<<n.
REQ-021 SHALL decode STATUS as: bit0 busy, bit1 done, bit2 timeout; bits[7:3] read 0.
REQ-022 SHALL implement the FSM states and transitions:
- IDLE -> SETUP on a CTRL write with start=1.
- SETUP -> ACCESS after exactly 1 cycle.
- ACCESS -> IDLE when pready=1, or when the timeout condition of REQ-026 is met.
REQ-023 SHALL in SETUP assert the selected psel bit with penable=0; paddr, pwrite and pwdata SHALL equal the latched ADDR, direction and WDATA.
REQ-024 SHALL in ACCESS hold psel, paddr, pwrite and pwdata stable, with penable=1.
REQ-025 SHALL on completion (pready=1 in ACCESS):
- capture prdata into RDATA on reads only (RDATA unchanged on writes);
- set done;
- deassert psel and penable on the next cycle.
REQ-026 SHALL count ACCESS cycles; if TIMEOUT cycles elapse with pready=0, abort, set timeout, leave RDATA unchanged, and return to IDLE.
REQ-027 SHALL treat pready=1 on the terminal-count cycle as a successful completion (pready wins over timeout).
REQ-028 SHALL keep busy=1 in SETUP and ACCESS; zero-wait-state latency is: start written at edge N, SETUP in cycle N+1, ACCESS in N+2, busy=0 and done=1 from N+3.
REQ-029 SHALL clear done and timeout on every accepted start.
REQ-030 SHALL ignore all CPU writes to ADDR, WDATA and CTRL while busy=1; reads remain valid.
REQ-031 SHALL drive paddr, pwdata and pwrite to 0 whenever the FSM is in IDLE.
REQ-032 SHALL ignore a CTRL write with start=0.

Reset
REQ-033 SHALL, on presetn=0 at any time including mid-transfer, asynchronously:
- enter IDLE;
- clear ADDR, WDATA, RDATA and STATUS;
- drive psel=0, penable=0, pwrite=0, paddr=0, pwdata=0 and irq=0.
REQ-034 SHALL start no transfer while presetn=0, and SHALL need a fresh start write after reset release.

Verification
REQ-035 Zero-wait read: ADDR=0x00000010, CTRL=0x05 (slave 1, read), pready=1, prdata=0xDEADBEEF -> psel=0x02 for 2 cycles, penable high 1 cycle, RDATA bytes 0x8..0xB read EF,BE,AD,DE, STATUS=0x02, irq=1.
REQ-036 Write with 3 wait states: ADDR=0x4, WDATA=0x12345678, CTRL=0x0B (slave 2, write) -> psel=0x04, pwdata=0x12345678 stable over 4 ACCESS cycles, RDATA unchanged, STATUS=0x02.
REQ-037 Timeout: TIMEOUT=4, pready held 0 -> penable high exactly 4 cycles, then psel=0, STATUS=0x04, irq=1.
REQ-038 Busy lockout: write ADDR byte 0 = 0xFF and CTRL=0x01 during ACCESS -> ADDR and paddr unchanged, no second transfer after completion.
REQ-039 Reset mid-ACCESS: presetn=0 -> psel, penable and irq are 0 immediately (before the next pclk edge), STATUS=0x00; after release, no APB activity until a new start.
REQ-040 Simultaneous: pready=1 on the terminal timeout cycle -> STATUS=0x02 and RDATA updated.

Source files
------------

// File: rtl/apb_byte_master.sv
// apb_byte_master: byte-wide CPU register window that launches single APB
// transfers (one slave selected per transfer) with a wait-state timeout.
module apb_byte_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic        cpu_cs,
   input  logic        cpu_we_n,
   input  logic [3:0]  cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic [7:0]  cpu_dout,
   output logic [31:0] paddr,
   output logic [7:0]  psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic        pready,
   input  logic [31:0] prdata,
   output logic        irq
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   // ACCESS cycle index at which the transfer is aborted if pready stays low
   localparam logic [7:0] TERM = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic [31:0] addr_word;
   logic [31:0] wdata_word;
   logic [31:0] rdata_word;
   logic        done;
   logic        timeout;
   logic        xfer_write;
   logic [2:0]  xfer_slave;
   logic [7:0]  count;
   logic        busy;
   logic        cpu_wr;
   logic        start_req;
   logic        complete;
   logic        expire;

   assign busy      = (state != IDLE);
   assign cpu_wr    = cpu_cs & ~cpu_we_n;
   // CTRL writes are only honoured while idle, so the window registers double as the latched transfer
   assign start_req = cpu_wr & ~busy & (cpu_addr == 4'hC) & cpu_din[0];
   assign complete  = (state == ACCESS) & pready;
   assign expire    = (state == ACCESS) & ~pready & (count == TERM);

   // State register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; pready takes priority over the terminal count
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start_req) next_state = SETUP;
         SETUP:   next_state = ACCESS;
         ACCESS:  if (pready || (count == TERM)) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // CPU-writable ADDR/WDATA bytes and the latched CTRL fields, locked while busy
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         addr_word  <= '0;
         wdata_word <= '0;
         xfer_write <= 1'b0;
         xfer_slave <= '0;
      end else if (cpu_wr && !busy) begin
         for (int i = 0; i < 4; i++) begin
            if (cpu_addr == 4'(i))     addr_word[i*8 +: 8]  <= cpu_din;
            if (cpu_addr == 4'(i + 4)) wdata_word[i*8 +: 8] <= cpu_din;
         end
         if (start_req) begin
            xfer_write <= cpu_din[1];
            xfer_slave <= cpu_din[4:2];
         end
      end
   end

   // ACCESS cycle counter, cleared in SETUP
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         count <= '0;
      end else if (state == SETUP) begin
         count <= '0;
      end else if (state == ACCESS) begin
         count <= count + 8'd1;
      end
   end

   // Status flags and read-data capture
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         done       <= 1'b0;
         timeout    <= 1'b0;
         rdata_word <= '0;
      end else if (start_req) begin
         done    <= 1'b0;
         timeout <= 1'b0;
      end else if (complete) begin
         done <= 1'b1;
         if (!xfer_write) rdata_word <= prdata;
      end else if (expire) begin
         timeout <= 1'b1;
      end
   end

   // CPU read mux; write-only and reserved offsets read as zero
   always_comb begin
      cpu_dout = 8'h00;
      if (cpu_cs && cpu_we_n) begin
         case (cpu_addr[3:2])
            2'd0:    cpu_dout = addr_word[cpu_addr[1:0]*8 +: 8];
            2'd1:    cpu_dout = wdata_word[cpu_addr[1:0]*8 +: 8];
            2'd2:    cpu_dout = rdata_word[cpu_addr[1:0]*8 +: 8];
            default: cpu_dout = (cpu_addr == 4'hD) ? {5'b0, timeout, done, busy} : 8'h00;
         endcase
      end
   end

   // APB outputs derived from state; the bus is parked at zero when idle
   always_comb begin
      psel    = busy ? (8'b1 << xfer_slave) : 8'h00;
      penable = (state == ACCESS);
      pwrite  = busy & xfer_write;
      paddr   = busy ? addr_word : 32'h0;
      pwdata  = busy ? wdata_word : 32'h0;
   end

   assign irq = done | timeout;

endmodule

// File: tb/tb_apb_byte_master.sv
// Directed bench for apb_byte_master (TIMEOUT = 4).
module tb_apb_byte_master;

   logic        pclk;
   logic        presetn;
   logic        cpu_cs;
   logic        cpu_we_n;
   logic [3:0]  cpu_addr;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic [31:0] paddr;
   logic [7:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic        pready;
   logic [31:0] prdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   apb_byte_master #(.TIMEOUT(4)) dut (
      .pclk     (pclk),
      .presetn  (presetn),
      .cpu_cs   (cpu_cs),
      .cpu_we_n (cpu_we_n),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_dout (cpu_dout),
      .paddr    (paddr),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .pwdata   (pwdata),
      .pready   (pready),
      .prdata   (prdata),
      .irq      (irq)
   );

   initial pclk = 1'b0;
   always #10 pclk = ~pclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      cpu_cs   = 1'b1;
      cpu_we_n = 1'b0;
      cpu_addr = a;
      cpu_din  = d;
      @(posedge pclk);
      #1;
      cpu_cs   = 1'b0;
      cpu_we_n = 1'b1;
   endtask

   task automatic chk_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
      logic [7:0] d;
      cpu_cs   = 1'b1;
      cpu_we_n = 1'b1;
      cpu_addr = a;
      #1;
      d = cpu_dout;
      cpu_cs = 1'b0;
      chk(tag, {24'h0, d}, {24'h0, exp});
   endtask

   initial begin
      int n;
      presetn  = 1'b0;
      cpu_cs   = 1'b0;
      cpu_we_n = 1'b1;
      cpu_addr = 4'h0;
      cpu_din  = 8'h00;
      pready   = 1'b0;
      prdata   = 32'h0;

      // reset state
      #3;
      chk("rst_psel", {24'h0, psel}, 32'h0);
      chk("rst_penable", {31'h0, penable}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_paddr", paddr, 32'h0);
      chk_rd("rst_status", 4'hD, 8'h00);
      #5 presetn = 1'b1;
      tick();

      // ADDR = 0x10, start=0 CTRL write is ignored
      wr(4'h0, 8'h10); wr(4'h1, 8'h00); wr(4'h2, 8'h00); wr(4'h3, 8'h00);
      chk_rd("addr_b0", 4'h0, 8'h10);
      chk_rd("reserved_e", 4'hE, 8'h00);
      wr(4'hC, 8'h02);
      chk_rd("nostart_status", 4'hD, 8'h00);
      chk("nostart_psel", {24'h0, psel}, 32'h0);

      // zero-wait read from slave 1
      pready = 1'b1;
      prdata = 32'hDEADBEEF;
      wr(4'hC, 8'h05);
      chk("zw_setup_psel", {24'h0, psel}, 32'h02);
      chk("zw_setup_penable", {31'h0, penable}, 32'h0);
      chk("zw_setup_paddr", paddr, 32'h10);
      chk("zw_setup_pwrite", {31'h0, pwrite}, 32'h0);
      chk_rd("zw_setup_status", 4'hD, 8'h01);
      chk_rd("ctrl_reads0", 4'hC, 8'h00);
      tick();
      chk("zw_access_psel", {24'h0, psel}, 32'h02);
      chk("zw_access_penable", {31'h0, penable}, 32'h1);
      tick();
      chk("zw_end_psel", {24'h0, psel}, 32'h0);
      chk("zw_end_penable", {31'h0, penable}, 32'h0);
      chk("zw_end_paddr", paddr, 32'h0);
      chk("zw_irq", {31'h0, irq}, 32'h1);
      chk_rd("zw_status", 4'hD, 8'h02);
      chk_rd("zw_rdata8", 4'h8, 8'hEF);
      chk_rd("zw_rdata9", 4'h9, 8'hBE);
      chk_rd("zw_rdataA", 4'hA, 8'hAD);
      chk_rd("zw_rdataB", 4'hB, 8'hDE);
      pready = 1'b0;

      // write to slave 2 with 3 wait states
      wr(4'h0, 8'h04);
      wr(4'h4, 8'h78); wr(4'h5, 8'h56); wr(4'h6, 8'h34); wr(4'h7, 8'h12);
      prdata = 32'hCAFEF00D;
      wr(4'hC, 8'h0B);
      chk("ws_setup_psel", {24'h0, psel}, 32'h04);
      chk("ws_setup_pwrite", {31'h0, pwrite}, 32'h1);
      chk("ws_setup_paddr", paddr, 32'h4);
      chk("ws_setup_irq", {31'h0, irq}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("ws_acc%0d_penable", i), {31'h0, penable}, 32'h1);
         chk($sformatf("ws_acc%0d_pwdata", i), pwdata, 32'h12345678);
         chk($sformatf("ws_acc%0d_psel", i), {24'h0, psel}, 32'h04);
         if (i == 3) pready = 1'b1;
      end
      tick();
      pready = 1'b0;
      chk("ws_end_pwdata", pwdata, 32'h0);
      chk("ws_end_pwrite", {31'h0, pwrite}, 32'h0);
      chk_rd("ws_status", 4'hD, 8'h02);
      chk_rd("ws_rdata8", 4'h8, 8'hEF);
      chk_rd("ws_rdataB", 4'hB, 8'hDE);

      // timeout with pready held low
      wr(4'hC, 8'h01);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (penable) n++;
      end
      chk("to_penable_cycles", n, 32'd4);
      chk("to_psel", {24'h0, psel}, 32'h0);
      chk("to_irq", {31'h0, irq}, 32'h1);
      chk_rd("to_status", 4'hD, 8'h04);
      chk_rd("to_rdata8", 4'h8, 8'hEF);

      // pready on the terminal-count cycle completes the read
      prdata = 32'hA5A55A5A;
      wr(4'hC, 8'h01);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 3) pready = 1'b1;
      end
      tick();
      pready = 1'b0;
      chk_rd("sim_status", 4'hD, 8'h02);
      chk_rd("sim_rdata8", 4'h8, 8'h5A);
      chk_rd("sim_rdataB", 4'hB, 8'hA5);

      // busy lockout
      wr(4'h0, 8'h20);
      prdata = 32'h11223344;
      wr(4'hC, 8'h01);
      tick();
      wr(4'h0, 8'hFF);
      wr(4'hC, 8'h01);
      chk("bl_penable", {31'h0, penable}, 32'h1);
      chk("bl_paddr", paddr, 32'h20);
      chk_rd("bl_addr_b0", 4'h0, 8'h20);
      pready = 1'b1;
      tick();
      pready = 1'b0;
      chk_rd("bl_status", 4'hD, 8'h02);
      chk_rd("bl_rdata8", 4'h8, 8'h44);
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (psel != 8'h00) n++;
      end
      chk("bl_no_second_xfer", n, 32'd0);

      // reset in the middle of ACCESS
      wr(4'hC, 8'h09);
      tick();
      chk("rm_penable_before", {31'h0, penable}, 32'h1);
      chk("rm_psel_before", {24'h0, psel}, 32'h04);
      #2 presetn = 1'b0;
      #1;
      chk("rm_psel", {24'h0, psel}, 32'h0);
      chk("rm_penable", {31'h0, penable}, 32'h0);
      chk("rm_irq", {31'h0, irq}, 32'h0);
      chk("rm_paddr", paddr, 32'h0);
      chk_rd("rm_status", 4'hD, 8'h00);
      chk_rd("rm_addr_b0", 4'h0, 8'h00);
      chk_rd("rm_rdata8", 4'h8, 8'h00);
      #2 presetn = 1'b1;
      pready = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (psel != 8'h00 || penable) n++;
      end
      chk("rm_no_activity", n, 32'd0);
      chk_rd("rm_status_after", 4'hD, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
